// File: rtl/cs_arb_pkg.sv
// rtl/cs_arb_pkg.sv - shared state encoding and response constants for the config-space arbiter
// Contents: arbiter state enum, Avalon response codes, fill bit for synthesized timeout read data.
package cs_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_TOUT = 2'd3
  } cs_arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Timeout read data is this bit replicated across the data width (all-ones).
  localparam logic TOUT_RDATA_BIT = 1'b1;

endpackage

// File: rtl/cs_txn_timer.sv
// rtl/cs_txn_timer.sv - per-transaction cycle counter with expiry flag
// Ports: clk_i/rstn_i clock and async active-low reset; clear_i zeroes the count;
//        enable_i advances it; expire_o is high while the count equals TIMEOUT_CYCLES-1.
module cs_txn_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expire_o = (count_q == LAST);

  // Saturates at LAST so a command accepted on the expiry cycle still
  // times out in RSP unless the response arrives on the very next cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expire_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cs_port_arbiter.sv
// rtl/cs_port_arbiter.sv - two-requester round-robin arbiter for the P-tile config-space port
// Ports: r0_* (HPS bridge) and r1_* (internal master) Avalon-MM requester sides;
//        cs_* command to / response from the P-tile; timeout_o and stale_rsp_o event
//        pulses; owner_o the current or last granted requester.
module cs_port_arbiter
  import cs_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [ADDR_WIDTH-1:0]   r0_address_i,
  input  logic [DATA_WIDTH-1:0]   r0_writedata_i,
  input  logic                    r0_read_i,
  input  logic                    r0_write_i,
  input  logic [DATA_WIDTH/8-1:0] r0_byteenable_i,
  output logic                    r0_waitrequest_o,
  output logic                    r0_readdatavalid_o,
  output logic                    r0_writerespvalid_o,
  output logic [DATA_WIDTH-1:0]   r0_readdata_o,
  output logic [RESP_WIDTH-1:0]   r0_resp_o,
  input  logic [ADDR_WIDTH-1:0]   r1_address_i,
  input  logic [DATA_WIDTH-1:0]   r1_writedata_i,
  input  logic                    r1_read_i,
  input  logic                    r1_write_i,
  input  logic [DATA_WIDTH/8-1:0] r1_byteenable_i,
  output logic                    r1_waitrequest_o,
  output logic                    r1_readdatavalid_o,
  output logic                    r1_writerespvalid_o,
  output logic [DATA_WIDTH-1:0]   r1_readdata_o,
  output logic [RESP_WIDTH-1:0]   r1_resp_o,
  output logic [ADDR_WIDTH-1:0]   cs_address_o,
  output logic [DATA_WIDTH-1:0]   cs_writedata_o,
  output logic                    cs_read_o,
  output logic                    cs_write_o,
  output logic [DATA_WIDTH/8-1:0] cs_byteenable_o,
  input  logic                    cs_waitrequest_i,
  input  logic                    cs_readdatavalid_i,
  input  logic                    cs_writerespvalid_i,
  input  logic [DATA_WIDTH-1:0]   cs_readdata_i,
  input  logic [RESP_WIDTH-1:0]   cs_resp_i,
  output logic                    timeout_o,
  output logic                    stale_rsp_o,
  output logic                    owner_o
);

  cs_arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic is_read_q, is_read_d;    // latched command type; read wins when both strobes are set
  logic from_cmd_q, from_cmd_d;  // timeout hit while the command was still stalled
  logic stale_rsp_q, stale_rsp_d;

  logic r0_pending, r1_pending, grant;
  logic cs_rsp_valid;
  logic timer_clear, timer_enable, timer_expire;

  logic                  owner_wait;
  logic                  rsp_rdv, rsp_wrv;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [RESP_WIDTH-1:0] rsp_resp;

  assign cs_rsp_valid = cs_readdatavalid_i | cs_writerespvalid_i;
  assign timer_enable = (state_q == ST_CMD) || (state_q == ST_RSP);

  // On a tie the requester that did not own the port last time wins.
  always_comb begin
    r0_pending = r0_read_i | r0_write_i;
    r1_pending = r1_read_i | r1_write_i;
    if (r0_pending && r1_pending) begin
      grant = ~owner_q;
    end else begin
      grant = r1_pending;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_read_d   = is_read_q;
    from_cmd_d  = from_cmd_q;
    timer_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (r0_pending || r1_pending) begin
          owner_d     = grant;
          is_read_d   = grant ? r1_read_i : r0_read_i;
          timer_clear = 1'b1;
          state_d     = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!cs_waitrequest_i) begin
          state_d = ST_RSP;
        end else if (timer_expire) begin
          state_d    = ST_TOUT;
          from_cmd_d = 1'b1;
        end
      end
      ST_RSP: begin
        // A response on the expiry cycle takes priority over the timeout.
        if (cs_rsp_valid) begin
          state_d = ST_IDLE;
        end else if (timer_expire) begin
          state_d    = ST_TOUT;
          from_cmd_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Responses seen outside RSP belong to no live transaction and are dropped.
  assign stale_rsp_d = cs_rsp_valid && (state_q != ST_RSP);

  always_comb begin
    cs_address_o    = '0;
    cs_writedata_o  = '0;
    cs_byteenable_o = '0;
    cs_read_o       = 1'b0;
    cs_write_o      = 1'b0;
    owner_wait      = 1'b1;
    rsp_rdv         = 1'b0;
    rsp_wrv         = 1'b0;
    rsp_data        = '0;
    rsp_resp        = RESP_WIDTH'(RESP_OKAY);
    case (state_q)
      ST_CMD: begin
        cs_address_o    = owner_q ? r1_address_i    : r0_address_i;
        cs_writedata_o  = owner_q ? r1_writedata_i  : r0_writedata_i;
        cs_byteenable_o = owner_q ? r1_byteenable_i : r0_byteenable_i;
        cs_read_o       = is_read_q;
        cs_write_o      = ~is_read_q;
        owner_wait      = cs_waitrequest_i;
      end
      ST_RSP: begin
        rsp_rdv  = cs_readdatavalid_i;
        rsp_wrv  = cs_writerespvalid_i;
        rsp_data = cs_readdata_i;
        rsp_resp = cs_resp_i;
      end
      ST_TOUT: begin
        rsp_rdv    = is_read_q;
        rsp_wrv    = ~is_read_q;
        rsp_data   = is_read_q ? {DATA_WIDTH{TOUT_RDATA_BIT}} : '0;
        rsp_resp   = RESP_WIDTH'(RESP_SLVERR);
        // Completes the stalled command so the requester can move on.
        owner_wait = ~from_cmd_q;
      end
      default: ;
    endcase

    r0_waitrequest_o    = owner_q ? 1'b1 : owner_wait;
    r1_waitrequest_o    = owner_q ? owner_wait : 1'b1;
    r0_readdatavalid_o  = ~owner_q & rsp_rdv;
    r0_writerespvalid_o = ~owner_q & rsp_wrv;
    r0_readdata_o       = owner_q ? '0 : rsp_data;
    r0_resp_o           = owner_q ? '0 : rsp_resp;
    r1_readdatavalid_o  = owner_q & rsp_rdv;
    r1_writerespvalid_o = owner_q & rsp_wrv;
    r1_readdata_o       = owner_q ? rsp_data : '0;
    r1_resp_o           = owner_q ? rsp_resp : '0;
  end

  assign timeout_o   = (state_q == ST_TOUT);
  assign stale_rsp_o = stale_rsp_q;
  assign owner_o     = owner_q;

  cs_txn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clear_i  (timer_clear),
    .enable_i (timer_enable),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b1;
      is_read_q   <= 1'b0;
      from_cmd_q  <= 1'b0;
      stale_rsp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_read_q   <= is_read_d;
      from_cmd_q  <= from_cmd_d;
      stale_rsp_q <= stale_rsp_d;
    end
  end

endmodule
